// File: rtl/stateful_pkg.sv
// Shared types and default parameters for the stateful accumulator.
package stateful_pkg;

  typedef enum logic [0:0] {
    MODE_INDEP   = 1'b0,
    MODE_CASCADE = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 2;

endpackage

// File: rtl/stateful_step_counter.sv
// One wrapping WIDTH-bit step counter; rst beats clr, clr beats en.
module stateful_step_counter #(
  parameter int WIDTH = stateful_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;

  // Next-count selection.
  always_comb begin
    s_d = s_q;
    if (clr) begin
      s_d = '0;
    end else if (en) begin
      s_d = s_q + WIDTH'(1);
    end else begin
      s_d = s_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/stateful_accum.sv
// Multi-channel step accumulator with sticky overflow.
// Define STATEFUL_ACCUM_SAT_EN to saturate accumulators on carry-out instead of wrapping.
module stateful_accum
  import stateful_pkg::*;
#(
  parameter int    WIDTH    = DEF_WIDTH,
  parameter int    CHANNELS = DEF_CHANNELS,
  parameter mode_e MODE     = MODE_INDEP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [CHANNELS*WIDTH-1:0] step,
  output logic [CHANNELS-1:0]       ovf
);

  logic [WIDTH-1:0]   s_w   [CHANNELS];
  logic [WIDTH-1:0]   src_w [CHANNELS];
  logic [WIDTH-1:0]   a_q   [CHANNELS];
  logic [WIDTH-1:0]   a_d   [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    stateful_step_counter #(.WIDTH(WIDTH)) u_step (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .s   (s_w[c])
    );

    if (MODE == MODE_CASCADE && c > 0) begin : g_cascade
      logic [WIDTH-1:0] stp_q;
      logic [WIDTH-1:0] stp_d;

      assign src_w[c] = a_q[c-1];

      // Step output remembers the upstream value applied on the last advance.
      always_comb begin
        stp_d = stp_q;
        if (clr) begin
          stp_d = '0;
        end else if (en) begin
          stp_d = src_w[c];
        end else begin
          stp_d = stp_q;
        end
      end

      // Applied-step register.
      always_ff @(posedge clk) begin
        if (rst) begin
          stp_q <= '0;
        end else begin
          stp_q <= stp_d;
        end
      end

      assign step[c*WIDTH +: WIDTH] = stp_q;
    end else begin : g_indep
      assign src_w[c] = s_w[c];
      assign step[c*WIDTH +: WIDTH] = s_w[c];
    end

    assign cnt[c*WIDTH +: WIDTH] = a_q[c];
  end

  // Accumulate at WIDTH+1 bits so the carry-out can flag overflow.
  always_comb begin
    logic [WIDTH:0] sum;
    sum   = '0;
    ovf_d = ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      a_d[c] = a_q[c];
      sum    = {1'b0, a_q[c]} + {1'b0, src_w[c]};
      if (clr) begin
        a_d[c]   = '0;
        ovf_d[c] = 1'b0;
      end else if (en) begin
`ifdef STATEFUL_ACCUM_SAT_EN
        if (sum[WIDTH]) begin
          a_d[c] = '1;
        end else begin
          a_d[c] = sum[WIDTH-1:0];
        end
`else
        a_d[c] = sum[WIDTH-1:0];
`endif
        ovf_d[c] = ovf_q[c] | sum[WIDTH];
      end else begin
        a_d[c]   = a_q[c];
        ovf_d[c] = ovf_q[c];
      end
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        a_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        a_q[c] <= a_d[c];
      end
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_stateful_accum.sv
// Directed bench: an independent-mode and a cascade-mode instance driven in lockstep.
module tb_stateful_accum;
  import stateful_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] cnt_i;
  logic [7:0] step_i;
  logic [1:0] ovf_i;
  logic [7:0] cnt_c;
  logic [7:0] step_c;
  logic [1:0] ovf_c;

  int n_assert = 0;
  int n_fail   = 0;

  stateful_accum #(.WIDTH(4), .CHANNELS(2), .MODE(MODE_INDEP)) dut_indep (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .cnt  (cnt_i),
    .step (step_i),
    .ovf  (ovf_i)
  );

  stateful_accum #(.WIDTH(4), .CHANNELS(2), .MODE(MODE_CASCADE)) dut_casc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .cnt  (cnt_c),
    .step (step_c),
    .ovf  (ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    tick(2);
    check("reset_cnt_i",  32'(cnt_i),  32'h00);
    check("reset_step_i", 32'(step_i), 32'h00);
    check("reset_ovf_i",  32'(ovf_i),  32'h0);
    check("reset_cnt_c",  32'(cnt_c),  32'h00);

    // Four advances: indep 0+1+2+3, cascade ch1 0+0+1+3.
    rst = 1'b0;
    en  = 1'b1;
    tick(4);
    check("e4_cnt_i",  32'(cnt_i),  32'h66);
    check("e4_step_i", 32'(step_i), 32'h44);
    check("e4_cnt_c",  32'(cnt_c),  32'h46);
    check("e4_step_c", 32'(step_c), 32'h34);
    check("e4_ovf_c",  32'(ovf_c),  32'h0);

    tick(2);
    check("e6_step_i", 32'(step_i), 32'h66);
    check("e6_cnt_i",  32'(cnt_i),  32'hFF);
    check("e6_ovf_i",  32'(ovf_i),  32'h0);

    tick(1);
`ifdef STATEFUL_ACCUM_SAT_EN
    check("e7_cnt_i",  32'(cnt_i),  32'hFF);
`else
    check("e7_cnt_i",  32'(cnt_i),  32'h55);
`endif
    check("e7_ovf_i",  32'(ovf_i),  32'h3);

    tick(1);
`ifdef STATEFUL_ACCUM_SAT_EN
    check("e8_cnt_i",  32'(cnt_i),  32'hFF);
`else
    check("e8_cnt_i",  32'(cnt_i),  32'hCC);
`endif
    check("e8_ovf_i",  32'(ovf_i),  32'h3);
    check("e8_step_i", 32'(step_i), 32'h88);

    // clr together with en after five advances.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    clr = 1'b1;
    tick(1);
    check("clr_cnt_i",  32'(cnt_i),  32'h00);
    check("clr_step_i", 32'(step_i), 32'h00);
    check("clr_ovf_i",  32'(ovf_i),  32'h0);
    check("clr_cnt_c",  32'(cnt_c),  32'h00);
    check("clr_step_c", 32'(step_c), 32'h00);

    clr = 1'b0;
    tick(2);
    check("post_clr_cnt_i", 32'(cnt_i), 32'h11);

    rst = 1'b1;
    clr = 1'b1;
    tick(1);
    check("rstclr_cnt_i",  32'(cnt_i),  32'h00);
    check("rstclr_step_i", 32'(step_i), 32'h00);

    // Three advances, then three idle cycles.
    rst = 1'b0;
    clr = 1'b0;
    tick(3);
    en = 1'b0;
    tick(3);
    check("hold_cnt_i",  32'(cnt_i),  32'h33);
    check("hold_step_i", 32'(step_i), 32'h33);
    check("hold_ovf_i",  32'(ovf_i),  32'h0);

    en = 1'b1;
    tick(2);
    check("mid_cnt_i", 32'(cnt_i), 32'hAA);

    rst = 1'b1;
    tick(1);
    check("midrst_cnt_i",  32'(cnt_i),  32'h00);
    check("midrst_step_i", 32'(step_i), 32'h00);
    check("midrst_cnt_c",  32'(cnt_c),  32'h00);

    rst = 1'b0;
    tick(1);
    check("first_step_i", 32'(step_i), 32'h11);
    check("first_cnt_i",  32'(cnt_i),  32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
